eth_clkgen_multi: RTL and testbench

- Parametrised, fully digital successor to the Ethernet PLL wrapper.
- Derives NUM_CLOCKS divided, phase-offset clocks and edge strobes from refclk.
- Provides a lock sequencer and a runtime per-channel reconfiguration handshake.
- Sits after the board reference clock. Feeds slow-domain logic, e.g. MDIO and LED timing, that needs phase-related clocks without a hard PLL.

---
 rtl/eth_clkgen_pkg.sv | 16 +
 rtl/eth_clkgen_chan.sv | 54 +++++
 rtl/eth_clkgen_multi.sv | 123 ++++++++++++
 tb/tb_eth_clkgen_multi.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_clkgen_pkg.sv
// Shared types and helpers for the multi-channel digital clock generator.
package eth_clkgen_pkg;

  typedef enum logic [1:0] {
    LOCKWAIT,
    ALIGN,
    RUN,
    APPLY
  } state_t;

  // Channel-select width; a single channel still needs one select bit.
  function automatic int unsigned ch_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/eth_clkgen_chan.sv
// One divided, phase-offset clock channel with a rising-edge strobe.
module eth_clkgen_chan #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] phase,
  input  logic             align,
  input  logic             run,
  output logic             outclk,
  output logic             outstb
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;
  logic [DIV_W-1:0] start;
  logic [DIV_W-1:0] half;
  logic             armed;
  logic             armed_nxt;
  logic             clk_nxt;

  // armed holds the clock low until the counter first reaches zero, so a
  // large phase never produces an early partial high pulse.
  always_comb begin
    half      = div >> 1;
    start     = (phase == '0) ? '0 : div - phase;
    cnt_nxt   = '0;
    armed_nxt = 1'b0;
    if (align) begin
      cnt_nxt   = start;
      armed_nxt = (phase == '0);
    end else if (run) begin
      cnt_nxt   = (cnt == div - DIV_W'(1)) ? '0 : cnt + DIV_W'(1);
      armed_nxt = armed | (cnt_nxt == '0);
    end
    clk_nxt = (align | run) & armed_nxt & (cnt_nxt < half);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      armed  <= 1'b0;
      outclk <= 1'b0;
      outstb <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      armed  <= armed_nxt;
      outclk <= clk_nxt;
      outstb <= clk_nxt & ~outclk;
    end
  end

endmodule

// File: rtl/eth_clkgen_multi.sv
// Multi-channel digital clock generator: lock sequencer, per-channel
// divide/phase configuration and a runtime reconfiguration handshake.
module eth_clkgen_multi
  import eth_clkgen_pkg::*;
#(
  parameter int unsigned NUM_CLOCKS  = 2,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 4,
  parameter int unsigned LOCK_CYCLES = 64
) (
  input  logic                        refclk,
  input  logic                        rst,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [ch_w(NUM_CLOCKS)-1:0] cfg_chan,
  input  logic [DIV_W-1:0]            cfg_div,
  input  logic [DIV_W-1:0]            cfg_phase,
  output logic                        cfg_err,
  output logic [NUM_CLOCKS-1:0]       outclk,
  output logic [NUM_CLOCKS-1:0]       outstb,
  output logic                        locked
);

  localparam int unsigned CH_W   = ch_w(NUM_CLOCKS);
  localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);

  state_t            state;
  logic [LOCK_W-1:0] wcnt;
  logic [DIV_W-1:0]  div_q   [NUM_CLOCKS];
  logic [DIV_W-1:0]  phase_q [NUM_CLOCKS];
  logic [CH_W-1:0]   stg_chan;
  logic [DIV_W-1:0]  stg_div;
  logic [DIV_W-1:0]  stg_phase;

  logic req_ok_c;
  logic accept_c;
  logic run_c;
  logic align_c;

  // Channels stop at the accept edge so outputs are already low in APPLY.
  always_comb begin
    req_ok_c = (32'(cfg_chan) < NUM_CLOCKS) && (cfg_div >= DIV_W'(2)) &&
               (cfg_phase < cfg_div);
    accept_c = cfg_valid && cfg_ready && (state == RUN);
    run_c    = (state == RUN) && !(accept_c && req_ok_c);
    align_c  = (state == ALIGN);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= LOCKWAIT;
      wcnt      <= '0;
      locked    <= 1'b0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      stg_chan  <= '0;
      stg_div   <= '0;
      stg_phase <= '0;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        div_q[i]   <= DIV_W'(DEFAULT_DIV);
        phase_q[i] <= '0;
      end
    end else begin
      cfg_err <= 1'b0;
      case (state)
        LOCKWAIT: begin
          if (wcnt == LOCK_W'(LOCK_CYCLES)) begin
            state <= ALIGN;
            wcnt  <= '0;
          end else begin
            wcnt <= wcnt + LOCK_W'(1);
          end
        end
        ALIGN: begin
          state     <= RUN;
          locked    <= 1'b1;
          cfg_ready <= 1'b1;
        end
        RUN: begin
          if (accept_c) begin
            if (req_ok_c) begin
              stg_chan  <= cfg_chan;
              stg_div   <= cfg_div;
              stg_phase <= cfg_phase;
              state     <= APPLY;
              locked    <= 1'b0;
              cfg_ready <= 1'b0;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        APPLY: begin
          for (int i = 0; i < NUM_CLOCKS; i++) begin
            if (CH_W'(i) == stg_chan) begin
              div_q[i]   <= stg_div;
              phase_q[i] <= stg_phase;
            end
          end
          state <= LOCKWAIT;
          wcnt  <= '0;
        end
        default: state <= LOCKWAIT;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_chan
    eth_clkgen_chan #(
      .DIV_W(DIV_W)
    ) u_chan (
      .refclk(refclk),
      .rst   (rst),
      .div   (div_q[g]),
      .phase (phase_q[g]),
      .align (align_c),
      .run   (run_c),
      .outclk(outclk[g]),
      .outstb(outstb[g])
    );
  end

endmodule

// File: tb/tb_eth_clkgen_multi.sv
// Directed bench for eth_clkgen_multi; three channels so that an
// out-of-range channel index is representable on cfg_chan.
module tb_eth_clkgen_multi;

  localparam int NC = 3;
  localparam int DW = 8;
  localparam int CW = 2;

  logic          refclk;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_chan;
  logic [DW-1:0] cfg_div;
  logic [DW-1:0] cfg_phase;
  logic          cfg_err;
  logic [NC-1:0] outclk;
  logic [NC-1:0] outstb;
  logic          locked;

  int n_run;
  int n_fail;
  int k_run;
  int exp_div [NC];
  int exp_ph  [NC];

  typedef struct {
    logic v;
    int   chan;
    int   div;
    int   ph;
    logic err;
  } vec_t;

  vec_t tbl [6];

  eth_clkgen_multi #(
    .NUM_CLOCKS (NC),
    .DIV_W      (DW),
    .DEFAULT_DIV(4),
    .LOCK_CYCLES(64)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_div  (cfg_div),
    .cfg_phase(cfg_phase),
    .cfg_err  (cfg_err),
    .outclk   (outclk),
    .outstb   (outstb),
    .locked   (locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Channel reference: first rising edge at k=p, then period d, high d/2.
  function automatic logic model_clk(input int k, input int d, input int p);
    if (k < p) return 1'b0;
    return ((k - p) % d) < (d / 2);
  endfunction

  task automatic tick();
    @(negedge refclk);
    #1;
  endtask

  task automatic set_defaults();
    for (int i = 0; i < NC; i++) begin
      exp_div[i] = 4;
      exp_ph[i]  = 0;
    end
  endtask

  task automatic request(input int ch, input int d, input int p);
    cfg_valid   = 1'b1;
    cfg_chan    = CW'(ch);
    cfg_div     = DW'(d);
    cfg_phase   = DW'(p);
    exp_div[ch] = d;
    exp_ph[ch]  = p;
  endtask

  task automatic wait_lock(input string name, input int expected);
    int n = 0;
    while (n < 300) begin
      tick();
      n++;
      if (locked) break;
    end
    check(name, 32'(n), 32'(expected));
  endtask

  // Continuous output check: zero while unlocked, reference pattern while locked.
  always @(negedge refclk) begin
    logic [NC-1:0] ec;
    logic [NC-1:0] es;
    for (int i = 0; i < NC; i++) begin
      ec[i] = locked && model_clk(k_run, exp_div[i], exp_ph[i]);
      es[i] = ec[i] && !(k_run > 0 && model_clk(k_run - 1, exp_div[i], exp_ph[i]));
    end
    check("outclk_model", 32'(outclk), 32'(ec));
    check("outstb_model", 32'(outstb), 32'(es));
    k_run = locked ? k_run + 1 : 0;
  end

  initial begin
    logic [7:0] pat8;
    logic [9:0] pat10;
    int strobes;
    int first0;
    int first1;
    int second0;
    int hi;
    int n;

    n_run = 0;
    n_fail = 0;
    k_run = 0;
    set_defaults();
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_chan = '0;
    cfg_div = '0;
    cfg_phase = '0;

    tbl[0] = '{v: 1'b1, chan: 3, div: 4, ph: 0, err: 1'b1};
    tbl[1] = '{v: 1'b1, chan: 0, div: 1, ph: 0, err: 1'b1};
    tbl[2] = '{v: 1'b1, chan: 0, div: 4, ph: 4, err: 1'b1};
    tbl[3] = '{v: 1'b1, chan: 1, div: 0, ph: 0, err: 1'b1};
    tbl[4] = '{v: 1'b1, chan: 2, div: 3, ph: 5, err: 1'b1};
    tbl[5] = '{v: 1'b0, chan: 0, div: 6, ph: 1, err: 1'b0};

    repeat (3) tick();
    check("rst_locked", 32'(locked), 32'(0));
    check("rst_ready", 32'(cfg_ready), 32'(0));
    check("rst_err", 32'(cfg_err), 32'(0));
    check("rst_outclk", 32'(outclk), 32'(0));
    check("rst_outstb", 32'(outstb), 32'(0));

    rst = 1'b0;
    wait_lock("lock_after_reset", 66);
    check("ready_in_run", 32'(cfg_ready), 32'(1));
    pat8 = '0;
    strobes = 0;
    for (int k = 0; k < 8; k++) begin
      pat8[k] = outclk[0];
      strobes += int'(outstb[0]);
      tick();
    end
    check("default_pattern", 32'(pat8), 32'(8'h33));
    check("default_strobes", 32'(strobes), 32'(2));

    for (int i = 0; i < 6; i++) begin
      cfg_valid = tbl[i].v;
      cfg_chan  = CW'(tbl[i].chan);
      cfg_div   = DW'(tbl[i].div);
      cfg_phase = DW'(tbl[i].ph);
      tick();
      cfg_valid = 1'b0;
      check($sformatf("vec%0d_err", i), 32'(cfg_err), 32'(tbl[i].err));
      check($sformatf("vec%0d_locked", i), 32'(locked), 32'(1));
      tick();
      check($sformatf("vec%0d_err_clear", i), 32'(cfg_err), 32'(0));
      check($sformatf("vec%0d_ready", i), 32'(cfg_ready), 32'(1));
    end

    request(1, 5, 2);
    tick();
    cfg_valid = 1'b0;
    check("ch1_locked_drop", 32'(locked), 32'(0));
    check("ch1_ready_drop", 32'(cfg_ready), 32'(0));
    check("ch1_no_err", 32'(cfg_err), 32'(0));
    wait_lock("relock_ch1", 67);
    first0 = -1;
    first1 = -1;
    pat10 = '0;
    for (int k = 0; k < 20; k++) begin
      if (outstb[0] && first0 < 0) first0 = k;
      if (outstb[1] && first1 < 0) first1 = k;
      if (k < 10) pat10[k] = outclk[1];
      tick();
    end
    check("ch0_first_edge", 32'(first0), 32'(0));
    check("ch1_first_edge", 32'(first1), 32'(2));
    check("ch1_pattern", 32'(pat10), 32'(10'h18C));

    request(0, 6, 1);
    tick();
    cfg_chan  = CW'(2);
    cfg_div   = DW'(3);
    cfg_phase = DW'(0);
    n = 0;
    while (n < 300) begin
      tick();
      n++;
      if (locked) break;
      check("held_ready_err", 32'({cfg_ready, cfg_err}), 32'(0));
    end
    check("held_relock", 32'(n), 32'(67));
    check("held_ready_run", 32'(cfg_ready), 32'(1));
    exp_div[2] = 3;
    exp_ph[2]  = 0;
    tick();
    cfg_valid = 1'b0;
    check("held_accept_first_run", 32'(locked), 32'(0));
    wait_lock("relock_held", 67);
    repeat (20) tick();

    request(1, 7, 3);
    tick();
    cfg_valid = 1'b0;
    repeat (10) tick();
    check("mid_lockwait_locked", 32'(locked), 32'(0));
    rst = 1'b1;
    set_defaults();
    #1;
    check("mid_rst_outclk", 32'(outclk), 32'(0));
    check("mid_rst_locked", 32'(locked), 32'(0));
    check("mid_rst_ready", 32'(cfg_ready), 32'(0));
    tick();
    tick();
    rst = 1'b0;
    wait_lock("lock_after_mid_reset", 66);
    repeat (12) tick();

    check("run_outclk_high", 32'(outclk[0]), 32'(1));
    rst = 1'b1;
    set_defaults();
    #1;
    check("async_rst_locked", 32'(locked), 32'(0));
    check("async_rst_outclk", 32'(outclk), 32'(0));
    tick();
    rst = 1'b0;
    wait_lock("lock_after_async_reset", 66);

    request(0, 255, 254);
    tick();
    cfg_valid = 1'b0;
    wait_lock("relock_255", 67);
    first0 = -1;
    second0 = -1;
    hi = 0;
    for (int k = 0; k < 520; k++) begin
      if (outstb[0]) begin
        if (first0 < 0) first0 = k;
        else if (second0 < 0) second0 = k;
      end
      if (k < 509) hi += int'(outclk[0]);
      tick();
    end
    check("div255_first_edge", 32'(first0), 32'(254));
    check("div255_second_edge", 32'(second0), 32'(509));
    check("div255_high_cycles", 32'(hi), 32'(127));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
